// File: rtl/answer_window_timer.sv
// =============================================================================
// answer_window_timer
// -----------------------------------------------------------------------------
// Runs a timed answer window from a single fast clock. An internal prescaler
// turns TICKS_PER_SEC clock cycles into one-second ticks. While the window is
// open the block reports the remaining whole seconds and shows the live user
// count on an N-digit active-low seven-segment display. When the window ends
// (or is aborted) the count is frozen on the display, and one-cycle pulses go
// to the round controller.
//
// Parameters
//   TICKS_PER_SEC : clock cycles per second
//   WINDOW_SEC    : answer window length in seconds (>= 1)
//   COUNT_W       : width of userCount
//   NUM_DIGITS    : number of seven-segment digits driven (1..6)
//
// Ports
//   Clk100M     in   system clock, the only clock
//   Reset       in   synchronous, active-high reset
//   answerSig   in   start request, only looked at while idle
//   abortSig    in   cancel a running window
//   userCount   in   live user count (unsigned)
//   running     out  high while a window is active
//   secLeft     out  remaining whole seconds (0 when not running)
//   stopCount   out  one-cycle pulse at window end or abort
//   postSig     out  one-cycle pulse at normal window end only
//   answerSeg   out  digit k at [8k+7:8k], digit 0 least significant, active-low
//   o_dbg_state out  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Pulse contract with the round controller: stopCount and postSig are single
// cycle strobes with no back-pressure. The controller must take them in the
// cycle they are high; they are never held or repeated. postSig implies
// stopCount; stopCount alone means the window was aborted.
// =============================================================================
module answer_window_timer #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int WINDOW_SEC    = 5,
    parameter int COUNT_W       = 8,
    parameter int NUM_DIGITS    = 4
) (
    input  logic                    Clk100M,
    input  logic                    Reset,
    input  logic                    answerSig,
    input  logic                    abortSig,
    input  logic [COUNT_W-1:0]      userCount,
    output logic                    running,
    output logic [7:0]              secLeft,
    output logic                    stopCount,
    output logic                    postSig,
    output logic [8*NUM_DIGITS-1:0] answerSeg,
    output logic [1:0]              o_dbg_state
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    // Prescaler width; a one-cycle second still needs a one-bit register.
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    // Working width of the decimal converter; must be able to hold the
    // constant 10 even for very narrow counts.
    localparam int VW = (COUNT_W < 4) ? 4 : COUNT_W;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]    SEC_LOAD   = 8'(WINDOW_SEC);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'b1011_1111;

    function automatic logic [63:0] f_pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Largest value that fits on the display; anything above shows dashes.
    localparam logic [63:0] MAX_SHOWN = f_pow10(NUM_DIGITS) - 64'd1;

    // -------------------------------------------------------------------------
    // FSM state
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Timing registers
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic [7:0]    r_sec;
    logic [7:0]    w_sec_nxt;

    // Pulse registers
    logic r_stop;
    logic w_stop_nxt;
    logic r_post;
    logic w_post_nxt;

    // Count freezing
    logic               w_capture;
    logic [COUNT_W-1:0] r_frozen;
    logic [COUNT_W-1:0] w_frozen_nxt;
    logic               r_frozen_vld;
    logic               w_frozen_vld_nxt;

    // Display pipeline
    logic                    w_live;
    logic [COUNT_W-1:0]      w_disp_val;
    logic [8*NUM_DIGITS-1:0] w_seg_nxt;
    logic [8*NUM_DIGITS-1:0] r_seg;

    logic w_tick;

    // -------------------------------------------------------------------------
    // Seven-segment helpers
    // -------------------------------------------------------------------------
    function automatic logic [7:0] f_digit(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

    // Renders an unsigned value in decimal. Each digit above digit 0 is
    // blanked once the remaining quotient is zero, which blanks exactly the
    // leading zeros while digit 0 always shows something.
    function automatic logic [8*NUM_DIGITS-1:0] f_render(input logic [COUNT_W-1:0] v);
        logic [8*NUM_DIGITS-1:0] seg;
        logic [VW-1:0]           rem;
        logic [3:0]              d;
        seg = '1;
        rem = VW'(v);
        d   = 4'd0;
        if (64'(v) > MAX_SHOWN) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                seg[8*k +: 8] = SEG_DASH;
            end
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                d = 4'(rem % VW'(10));
                if ((k == 0) || (rem != '0)) begin
                    seg[8*k +: 8] = f_digit(d);
                end else begin
                    seg[8*k +: 8] = SEG_BLANK;
                end
                rem = rem / VW'(10);
            end
        end
        return seg;
    endfunction

    // -------------------------------------------------------------------------
    // State register and all sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_sec        <= '0;
            r_stop       <= 1'b0;
            r_post       <= 1'b0;
            r_frozen     <= '0;
            r_frozen_vld <= 1'b0;
            r_seg        <= '1;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_sec        <= w_sec_nxt;
            r_stop       <= w_stop_nxt;
            r_post       <= w_post_nxt;
            r_frozen     <= w_frozen_nxt;
            r_frozen_vld <= w_frozen_vld_nxt;
            r_seg        <= w_seg_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    assign w_tick = (r_presc == PRESC_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_sec_nxt   = r_sec;
        w_stop_nxt  = 1'b0;
        w_post_nxt  = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (answerSig) begin
                    w_state_nxt = ST_RUN;
                    w_presc_nxt = '0;
                    w_sec_nxt   = SEC_LOAD;
                end
            end

            ST_RUN: begin
                // Abort is checked first so it wins over a coincident final tick.
                if (abortSig) begin
                    w_state_nxt = ST_IDLE;
                    w_presc_nxt = '0;
                    w_sec_nxt   = '0;
                    w_stop_nxt  = 1'b1;
                    w_capture   = 1'b1;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    if (r_sec <= 8'd1) begin
                        w_state_nxt = ST_DONE;
                        w_sec_nxt   = '0;
                        w_stop_nxt  = 1'b1;
                        w_post_nxt  = 1'b1;
                        w_capture   = 1'b1;
                    end else begin
                        w_sec_nxt = r_sec - 8'd1;
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end

            ST_DONE: begin
                // Single cycle so a held answerSig cannot restart immediately.
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_presc_nxt = '0;
                w_sec_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Display source selection
    // -------------------------------------------------------------------------
    // The segment register is loaded with the rendering of what the source
    // will be after this edge, so a start edge already shows the live count
    // and an end edge already shows the frozen one.
    always_comb begin
        w_frozen_nxt     = w_capture ? userCount : r_frozen;
        w_frozen_vld_nxt = r_frozen_vld | w_capture;
        w_live           = (w_state_nxt == ST_RUN);
        w_disp_val       = w_live ? userCount : w_frozen_nxt;
        if (w_live || w_frozen_vld_nxt) begin
            w_seg_nxt = f_render(w_disp_val);
        end else begin
            w_seg_nxt = '1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign running     = (r_state == ST_RUN);
    assign secLeft     = r_sec;
    assign stopCount   = r_stop;
    assign postSig     = r_post;
    assign answerSeg   = r_seg;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_answer_window_timer.sv
// =============================================================================
// tb_answer_window_timer
// -----------------------------------------------------------------------------
// Bench for answer_window_timer with TICKS_PER_SEC=4, WINDOW_SEC=3,
// COUNT_W=16, NUM_DIGITS=4. A reference model tracks the window as a start
// cycle plus elapsed-cycle arithmetic and renders the display from the
// decimal string of the value. Directed scenarios are followed by random
// stimulus; every cycle's outputs are compared against the model.
// =============================================================================
module tb_answer_window_timer;

    localparam int TPS = 4;
    localparam int WIN = 3;
    localparam int CW  = 16;
    localparam int ND  = 4;
    localparam int EW  = 1 + 8 + 1 + 1 + 8*ND;

    // -------------------------------------------------------------------------
    // Clock and DUT signals
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            ans;
    logic            abrt;
    logic [CW-1:0]   uc;
    logic            running;
    logic [7:0]      sec_left;
    logic            stop_count;
    logic            post_sig;
    logic [8*ND-1:0] seg;
    logic [1:0]      dbg_state;

    answer_window_timer #(
        .TICKS_PER_SEC (TPS),
        .WINDOW_SEC    (WIN),
        .COUNT_W       (CW),
        .NUM_DIGITS    (ND)
    ) dut (
        .Clk100M     (clk),
        .Reset       (rst),
        .answerSig   (ans),
        .abortSig    (abrt),
        .userCount   (uc),
        .running     (running),
        .secLeft     (sec_left),
        .stopCount   (stop_count),
        .postSig     (post_sig),
        .answerSeg   (seg),
        .o_dbg_state (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [8*ND-1:0] ref_seg(input int v);
        logic [8*ND-1:0] r;
        string s;
        int len;
        r = '1;
        if (v > 9999) begin
            for (int k = 0; k < ND; k++) r[8*k +: 8] = 8'hBF;
        end else begin
            s   = $sformatf("%0d", v);
            len = s.len();
            for (int k = 0; k < len; k++) begin
                r[8*k +: 8] = seg_lut[int'(s.getc(len - 1 - k)) - 48];
            end
        end
        return r;
    endfunction

    bit            m_in_win    = 1'b0;
    bit            m_done_hold = 1'b0;
    bit            m_frz_vld   = 1'b0;
    int            m_cyc       = 0;
    int            m_start     = 0;
    logic [CW-1:0] m_frz       = '0;

    // Advances the model by one clock edge using the inputs the DUT saw.
    task automatic model_advance();
        bit              e_stop;
        bit              e_post;
        int              e_sec;
        logic [8*ND-1:0] e_seg;
        m_cyc++;
        e_stop = 1'b0;
        e_post = 1'b0;
        if (rst) begin
            m_in_win    = 1'b0;
            m_done_hold = 1'b0;
            m_frz_vld   = 1'b0;
        end else if (m_in_win) begin
            if (abrt) begin
                m_in_win  = 1'b0;
                e_stop    = 1'b1;
                m_frz     = uc;
                m_frz_vld = 1'b1;
            end else if (m_cyc - m_start == WIN * TPS) begin
                m_in_win    = 1'b0;
                m_done_hold = 1'b1;
                e_stop      = 1'b1;
                e_post      = 1'b1;
                m_frz       = uc;
                m_frz_vld   = 1'b1;
            end
        end else if (m_done_hold) begin
            m_done_hold = 1'b0;
        end else if (ans) begin
            m_in_win = 1'b1;
            m_start  = m_cyc;
        end
        e_sec = m_in_win ? (WIN - (m_cyc - m_start) / TPS) : 0;
        if (m_in_win)       e_seg = ref_seg(int'(uc));
        else if (m_frz_vld) e_seg = ref_seg(int'(m_frz));
        else                e_seg = '1;
        exp_q.push_back({m_in_win, 8'(e_sec), e_stop, e_post, e_seg});
    endtask

    // -------------------------------------------------------------------------
    // Driver: one clock step, then compare every output with the model
    // -------------------------------------------------------------------------
    task automatic step();
        logic [EW-1:0] e;
        @(posedge clk);
        #1;
        model_advance();
        e = exp_q.pop_front();
        chk("running",   32'(running),    32'(e[EW-1]));
        chk("secLeft",   32'(sec_left),   32'(e[EW-2 -: 8]));
        chk("stopCount", 32'(stop_count), 32'(e[8*ND+1]));
        chk("postSig",   32'(post_sig),   32'(e[8*ND]));
        chk("answerSeg", seg,             e[8*ND-1:0]);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst  = 1'b1;
        ans  = 1'b0;
        abrt = 1'b0;
        uc   = '0;
        step();
        step();
        chk("lit_reset_seg", seg, 32'hFFFF_FFFF);
        chk("lit_reset_run", 32'(running), 32'd0);
        rst = 1'b0;
        repeat (3) step();
        chk("lit_idle_seg_blank", seg, 32'hFFFF_FFFF);

        // Normal window with known timing
        uc  = 16'd47;
        ans = 1'b1;
        step();
        ans = 1'b0;
        chk("lit_start_run", 32'(running), 32'd1);
        chk("lit_start_sec", 32'(sec_left), 32'd3);
        chk("lit_live_47", seg, 32'hFFFF_99F8);
        for (int i = 1; i <= 13; i++) begin
            if (i == 12) uc = 16'd12;
            step();
            if (i == 4) chk("lit_sec_2", 32'(sec_left), 32'd2);
            if (i == 8) chk("lit_sec_1", 32'(sec_left), 32'd1);
            if (i == 12) begin
                chk("lit_end_post", 32'(post_sig), 32'd1);
                chk("lit_end_stop", 32'(stop_count), 32'd1);
                chk("lit_end_run", 32'(running), 32'd0);
                chk("lit_end_sec", 32'(sec_left), 32'd0);
            end
            if (i == 13) begin
                chk("lit_after_post", 32'(post_sig), 32'd0);
                chk("lit_after_stop", 32'(stop_count), 32'd0);
            end
        end

        // Frozen display holds until the next start
        uc = 16'd99;
        step();
        chk("lit_frozen_12a", seg, 32'hFFFF_F9A4);
        step();
        chk("lit_frozen_12b", seg, 32'hFFFF_F9A4);
        ans = 1'b1;
        step();
        ans = 1'b0;
        chk("lit_live_99", seg, 32'hFFFF_9090);
        chk("lit_restart_sec", 32'(sec_left), 32'd3);

        // Decimal rendering inside a running window
        uc = 16'd0;     step(); chk("lit_seg_0",     seg, 32'hFFFF_FFC0);
        uc = 16'd1205;  step(); chk("lit_seg_1205",  seg, 32'hF9A4_C092);
        uc = 16'd10000; step(); chk("lit_seg_10000", seg, 32'hBFBF_BFBF);
        uc = 16'd9999;  step(); chk("lit_seg_9999",  seg, 32'h9090_9090);

        // Abort mid-window
        abrt = 1'b1;
        step();
        abrt = 1'b0;
        chk("lit_abort_stop", 32'(stop_count), 32'd1);
        chk("lit_abort_post", 32'(post_sig), 32'd0);
        chk("lit_abort_run", 32'(running), 32'd0);
        chk("lit_abort_sec", 32'(sec_left), 32'd0);
        chk("lit_abort_frozen", seg, 32'h9090_9090);
        step();
        chk("lit_abort_stop_low", 32'(stop_count), 32'd0);

        // answerSig held high: no restart while running or in the done cycle
        ans = 1'b1;
        step();
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 11) chk("lit_held_no_post", 32'(post_sig), 32'd0);
            if (i == 12) chk("lit_held_post", 32'(post_sig), 32'd1);
            if (i == 13) chk("lit_held_done_idle", 32'(running), 32'd0);
            if (i == 14) begin
                chk("lit_held_restart", 32'(running), 32'd1);
                chk("lit_held_reload", 32'(sec_left), 32'd3);
            end
        end
        ans = 1'b0;

        // Abort coincident with the final tick
        repeat (11) step();
        abrt = 1'b1;
        step();
        abrt = 1'b0;
        chk("lit_coinc_post", 32'(post_sig), 32'd0);
        chk("lit_coinc_stop", 32'(stop_count), 32'd1);
        step();

        // Reset in the middle of a window
        ans = 1'b1;
        step();
        ans = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("lit_midrst_run", 32'(running), 32'd0);
        chk("lit_midrst_seg", seg, 32'hFFFF_FFFF);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("lit_midrst_no_pulse", 32'(stop_count | post_sig), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            ans  = ($urandom_range(0, 3) == 0);
            abrt = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       uc = CW'($urandom_range(0, 9));
                1:       uc = CW'($urandom_range(0, 999));
                2:       uc = CW'($urandom_range(9990, 10010));
                default: uc = CW'($urandom_range(0, 65535));
            endcase
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/answer_window_timer.md
Name: answer_window_timer

Overview:
Parametrised successor to the fixed 5-second answer-period block. Runs a timed answer window from a single fast clock using an internal seconds prescaler, reports remaining seconds, and drives an N-digit active-low seven-segment display of the user's count in decimal. At window end it issues one-cycle stop/post pulses to the round controller. It also supports abort and freezes the final count on the display.

Parameters:
TICKS_PER_SEC, 100000000, clock cycles per second (set small in simulation)
WINDOW_SEC, 5, answer window length in seconds (>=1)
COUNT_W, 8, width of userCount
NUM_DIGITS, 4, number of seven-segment digits driven (1..6)

Ports:
Clk100M  in  1  system clock; the only clock
Reset  in  1  synchronous, active-high reset
answerSig  in  1  start request; sampled only in IDLE
abortSig  in  1  cancel a running window
userCount  in  COUNT_W  live user count (unsigned)
running  out  1  high while a window is active
secLeft  out  8  remaining whole seconds
stopCount  out  1  one-cycle pulse at window end or abort
postSig  out  1  one-cycle pulse at normal window end only
answerSeg  out  8*NUM_DIGITS  digit k at bits [8k+7:8k], digit 0 least significant, active-low

Behaviour:
- Reset: one clock, synchronous, active-high. Outputs: state IDLE, running=0, secLeft=0, stopCount=0, postSig=0, every digit 8'hFF (blank), prescaler=0. Reset mid-window discards the window and emits no pulses.
- States: IDLE, RUN, DONE.
- IDLE: answerSig=1 at edge E moves to RUN at E. From E: running=1, secLeft=WINDOW_SEC, prescaler=0, display live.
- RUN:
  - Prescaler increments each cycle. At TICKS_PER_SEC-1 it wraps to 0 and generates a tick.
  - Each tick decrements secLeft.
  - The tick that brings secLeft from 1 to 0 (edge E+WINDOW_SEC*TICKS_PER_SEC) goes to DONE. On that edge: running=0, postSig=1, stopCount=1, and the frozen count is captured from userCount.
  - answerSig is ignored in RUN (no restart).
- DONE: lasts exactly one cycle. postSig and stopCount return to 0. Next state is IDLE. answerSig is ignored in DONE.
- Abort: abortSig=1 in RUN at any edge goes to IDLE on that edge. running=0, secLeft=0, stopCount=1 for one cycle, postSig stays 0, and the count is frozen as for a normal end. If abort and the final tick coincide, abort wins.
- Display source:
  - Live registered userCount while running.
  - Frozen value after DONE or abort, held until the next start.
  - Blank (all digits FF) from reset until the first start.
  - Segment outputs lag the source by 1 cycle.
- Decimal conversion: unsigned value V rendered in base 10 across NUM_DIGITS.
  - Leading zeros are blanked (FF). Digit 0 always shows a digit, so V=0 shows "0".
  - If V > 10^NUM_DIGITS-1, every digit shows dash 8'b10111111.
- Digit codes, active-low, bit7 = dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- Start in IDLE after a previous window begins a fresh window. Prescaler and secLeft are reloaded, and the display returns to live.

Test Plan:
- TICKS_PER_SEC=4, WINDOW_SEC=3: reset, then answerSig pulse at edge 10 -> running=1 at edge 10; secLeft 3→2→1 at edges 14, 18; at edge 22 postSig=stopCount=1, running=0, secLeft=0; both pulses low at edge 23.
- During RUN (same params), answerSig held high continuously -> no restart; pulse occurs only at edge 22, single cycle. In IDLE after DONE, answerSig -> new window; secLeft reloads to 3.
- abortSig at edge 17 in RUN -> stopCount=1 for one cycle, postSig never asserts, running=0, secLeft=0. Repeat with abort coincident with the final tick -> postSig stays 0.
- NUM_DIGITS=4, COUNT_W=16:
  - userCount=0 -> {FF,FF,FF,C0}.
  - userCount=47 -> {FF,FF,99,F8}.
  - userCount=1205 -> {F9,A4,C0,92}.
  - userCount=10000 -> all digits BF.
  - Each result appears 1 cycle after the userCount change.
- userCount=12 at window end, then changed to 99 -> display stays "12" until the next answerSig, then tracks 99. Initially after reset, all digits are FF.
- Reset asserted mid-RUN at edge 16 -> edge 16 shows running=0 and digits FF; no postSig or stopCount pulse ever follows.
